// File: rtl/axis_count_checker_if.sv
// Stream bundle for the count checker: the upstream count stream (s_*)
// and the per-packet result stream (m_*). The slave view belongs to the
// checker; the master view belongs to whatever drives counts and consumes results.
interface axis_count_checker_if #(
  parameter int BEAT_W = 16
);

  // upstream count stream
  logic [31:0]       s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;

  // result stream, one beat per packet
  logic [31:0]       m_sum;
  logic [BEAT_W-1:0] m_beats;
  logic [1:0]        m_error;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready,
    output m_sum,
    output m_beats,
    output m_error,
    output m_valid,
    input  m_ready
  );

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready,
    input  m_sum,
    input  m_beats,
    input  m_error,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/axis_count_checker.sv
// Self-checking sink for the up-counter stream. Each packet must be the
// contiguous run 0,1,2,...; the block sums the beats, counts them (saturating)
// and emits one registered result beat per packet, flagging a sequence
// mismatch (bit0) or beat-count saturation (bit1).
module axis_count_checker #(
  parameter int BEAT_W = 16,
  parameter int PKT_W  = 16
) (
  input  logic               counter_clk,
  input  logic               reset,
  axis_count_checker_if.slave bus,
  output logic [PKT_W-1:0]   pkt_count
);

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    EMIT   = 1'b1
  } state_t;

  state_t            state;

  // running per-packet state
  logic [31:0]       sum_acc;
  logic [BEAT_W-1:0] beat_acc;
  logic [31:0]       expected;
  logic              seq_flag;
  logic              ovf_flag;

  // result registers
  logic [31:0]       m_sum_r;
  logic [BEAT_W-1:0] m_beats_r;
  logic [1:0]        m_error_r;

  // values including the beat currently offered
  logic              s_ready_int;
  logic              beat_fire;
  logic [31:0]       sum_next;
  logic [BEAT_W-1:0] beat_next;
  logic              seq_next;
  logic              ovf_next;
  logic              beat_at_max;

  // Ready is a pure decode of state so nothing upstream can loop back into it.
  assign s_ready_int = (state == ACCEPT);
  assign beat_fire   = bus.s_valid & s_ready_int;

  // Accumulator updates for the offered beat; saturate the beat count at all-ones.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    sum_next    = sum_acc + bus.s_data;
    beat_at_max = &beat_acc;
    beat_next   = beat_acc;
    ovf_next    = ovf_flag;
    seq_next    = seq_flag;
    if (beat_at_max) begin
      ovf_next = 1'b1;
    end else begin
      beat_next = beat_acc + BEAT_W'(1);
    end
    if (bus.s_data != expected) begin
      seq_next = 1'b1;
    end
  end

  // Packet FSM, accumulators, result registers and packet counter.
  always_ff @(posedge counter_clk or posedge reset) begin
    // NOTE: the reset branch clears every register here; there is no array storage, so nothing is left relying on power-up values.
    if (reset) begin
      state     <= ACCEPT;
      sum_acc   <= '0;
      beat_acc  <= '0;
      expected  <= '0;
      seq_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
      m_sum_r   <= '0;
      m_beats_r <= '0;
      m_error_r <= '0;
      pkt_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      case (state)
        ACCEPT: begin
          if (beat_fire) begin
            if (bus.s_last) begin
              // Close the packet: publish totals including this beat, start fresh.
              m_sum_r   <= sum_next;
              m_beats_r <= beat_next;
              m_error_r <= {ovf_next, seq_next};
              sum_acc   <= '0;
              beat_acc  <= '0;
              expected  <= '0;
              seq_flag  <= 1'b0;
              ovf_flag  <= 1'b0;
              state     <= EMIT;
            end else begin
              sum_acc   <= sum_next;
              beat_acc  <= beat_next;
              expected  <= expected + 32'd1;
              seq_flag  <= seq_next;
              ovf_flag  <= ovf_next;
            end
          end
        end
        EMIT: begin
          // Result is held until the consumer takes it; intake stays closed.
          if (bus.m_ready) begin
            pkt_count <= pkt_count + PKT_W'(1);
            state     <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  assign bus.s_ready = s_ready_int;
  assign bus.m_valid = (state == EMIT);
  assign bus.m_sum   = m_sum_r;
  assign bus.m_beats = m_beats_r;
  assign bus.m_error = m_error_r;

endmodule

// File: tb/tb_axis_count_checker.sv
// Bench for axis_count_checker. Two instances (BEAT_W 16 and 3) see the same
// stimulus; expected results for both are pushed when a packet is driven and
// popped by per-instance monitors when each result handshake happens.
module tb_axis_count_checker;

  typedef logic [31:0] word_q_t[$];

  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] beats;
    logic [1:0]  err;
  } res_t;

  logic        counter_clk;
  logic        reset;
  logic [15:0] pkt_count;
  logic [15:0] pkt_count3;

  int   vectors    = 0;
  int   miscompares = 0;
  int   exp_pkt    = 0;
  res_t sb16[$];
  res_t sb3[$];

  axis_count_checker_if #(.BEAT_W(16)) bus ();
  axis_count_checker_if #(.BEAT_W(3))  bus3 ();

  assign bus3.s_data  = bus.s_data;
  assign bus3.s_valid = bus.s_valid;
  assign bus3.s_last  = bus.s_last;
  assign bus3.m_ready = bus.m_ready;

  axis_count_checker #(.BEAT_W(16), .PKT_W(16)) dut (
    .counter_clk (counter_clk),
    .reset       (reset),
    .bus         (bus),
    .pkt_count   (pkt_count)
  );

  axis_count_checker #(.BEAT_W(3), .PKT_W(16)) dut3 (
    .counter_clk (counter_clk),
    .reset       (reset),
    .bus         (bus3),
    .pkt_count   (pkt_count3)
  );

  initial counter_clk = 1'b0;
  always #5 counter_clk = ~counter_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Result monitor, wide instance: a handshake seen here completes on the next edge.
  always @(negedge counter_clk) begin
    res_t e;
    res_t got;
    if (!reset && bus.m_valid && bus.m_ready) begin
      got = {bus.m_sum, bus.m_beats, bus.m_error};
      vectors++;
      if (sb16.size() == 0) begin
        miscompares++;
        $display("FAIL result16_unexpected: got sum=%0d beats=%0d err=%b, none pending", got.sum, got.beats, got.err);
      end else begin
        e = sb16.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL result16: got sum=%0d beats=%0d err=%b, want sum=%0d beats=%0d err=%b",
                   got.sum, got.beats, got.err, e.sum, e.beats, e.err);
        end
      end
    end
  end

  // Result monitor, narrow (BEAT_W=3) instance.
  always @(negedge counter_clk) begin
    res_t e;
    res_t got;
    if (!reset && bus3.m_valid && bus3.m_ready) begin
      got = {bus3.m_sum, 13'd0, bus3.m_beats, bus3.m_error};
      vectors++;
      if (sb3.size() == 0) begin
        miscompares++;
        $display("FAIL result3_unexpected: got sum=%0d beats=%0d err=%b, none pending", got.sum, got.beats, got.err);
      end else begin
        e = sb3.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL result3: got sum=%0d beats=%0d err=%b, want sum=%0d beats=%0d err=%b",
                   got.sum, got.beats, got.err, e.sum, e.beats, e.err);
        end
      end
    end
  end

  // Offer one beat and wait until it is accepted (ready seen before the edge).
  task automatic send_beat(input logic [31:0] d, input logic last);
    logic rdy;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge counter_clk);
      rdy = bus.s_ready;
      @(posedge counter_clk);
      #1;
      if (rdy) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL beat_timeout: beat %0d not accepted, want acceptance within 30 cycles", d);
  endtask

  // Reference model for both widths, then drive the packet.
  task automatic send_pkt(input word_q_t vals);
    logic [31:0] sum;
    int          c16, c3;
    logic        ovf16, ovf3, seq;
    sum = 0; c16 = 0; c3 = 0; ovf16 = 0; ovf3 = 0; seq = 0;
    for (int i = 0; i < vals.size(); i++) begin
      sum = sum + vals[i];
      if (c16 == 65535) ovf16 = 1; else c16++;
      if (c3 == 7) ovf3 = 1; else c3++;
      if (vals[i] != 32'(i)) seq = 1;
    end
    sb16.push_back({sum, 16'(c16), ovf16, seq});
    sb3.push_back({sum, 16'(c3), ovf3, seq});
    exp_pkt++;
    for (int i = 0; i < vals.size(); i++) begin
      send_beat(vals[i], (i == vals.size() - 1));
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_ramp(input int n);
    word_q_t q;
    for (int i = 0; i < n; i++) q.push_back(32'(i));
    send_pkt(q);
  endtask

  // Wait for all pending results to be consumed, then check the packet counters.
  task automatic drain;
    for (int n = 0; n < 60; n++) begin
      if (sb16.size() == 0 && sb3.size() == 0) break;
      @(posedge counter_clk);
      #1;
    end
    vectors++;
    if (sb16.size() != 0 || sb3.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: pending results %0d/%0d, want 0/0", sb16.size(), sb3.size());
      sb16.delete();
      sb3.delete();
    end
    vectors += 2;
    if (pkt_count !== 16'(exp_pkt)) begin
      miscompares++; $display("FAIL pkt_count: got %0d want %0d", pkt_count, exp_pkt);
    end
    if (pkt_count3 !== 16'(exp_pkt)) begin
      miscompares++; $display("FAIL pkt_count3: got %0d want %0d", pkt_count3, exp_pkt);
    end
  endtask

  task automatic check_reset_state(input string tag);
    vectors += 7;
    if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL %s s_ready: got %b want 1", tag, bus.s_ready); end
    if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL %s m_valid: got %b want 0", tag, bus.m_valid); end
    if (bus.m_sum !== 32'd0) begin miscompares++; $display("FAIL %s m_sum: got %0d want 0", tag, bus.m_sum); end
    if (bus.m_beats !== 16'd0) begin miscompares++; $display("FAIL %s m_beats: got %0d want 0", tag, bus.m_beats); end
    if (bus.m_error !== 2'b00) begin miscompares++; $display("FAIL %s m_error: got %b want 00", tag, bus.m_error); end
    if (pkt_count !== 16'd0) begin miscompares++; $display("FAIL %s pkt_count: got %0d want 0", tag, pkt_count); end
    if (bus3.m_valid !== 1'b0 || bus3.s_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s dut3 handshake: got valid=%b ready=%b want 0/1", tag, bus3.m_valid, bus3.s_ready);
    end
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge counter_clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    @(posedge counter_clk);
    #1;
  endtask

  task automatic test_basic;
    bus.m_ready = 1'b1;
    send_ramp(5);
    vectors += 3;
    if (bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL basic dead_cycle s_ready: got %b want 0", bus.s_ready); end
    if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL basic latency m_valid: got %b want 1", bus.m_valid); end
    @(posedge counter_clk);
    #1;
    if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL basic ready_return s_ready: got %b want 1", bus.s_ready); end
    drain();
  endtask

  task automatic test_back_to_back;
    bus.m_ready = 1'b1;
    send_ramp(4);
    send_ramp(3);
    drain();
  endtask

  task automatic test_seq_error;
    word_q_t q;
    bus.m_ready = 1'b1;
    q.push_back(32'd0);
    q.push_back(32'd1);
    q.push_back(32'd3);
    q.push_back(32'd3);
    send_pkt(q);
    send_ramp(2);
    drain();
  endtask

  task automatic test_hold;
    bus.m_ready = 1'b0;
    send_ramp(4);
    // Offer a single-beat packet during the hold; it must wait for the handshake.
    bus.s_data  = 32'd0;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors += 4;
      if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL hold m_valid cycle %0d: got %b want 1", i, bus.m_valid); end
      if (bus.m_sum !== 32'd6) begin miscompares++; $display("FAIL hold m_sum cycle %0d: got %0d want 6", i, bus.m_sum); end
      if (bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL hold s_ready cycle %0d: got %b want 0", i, bus.s_ready); end
      if (pkt_count !== 16'(exp_pkt - 1)) begin miscompares++; $display("FAIL hold pkt_count cycle %0d: got %0d want %0d", i, pkt_count, exp_pkt - 1); end
      @(posedge counter_clk);
      #1;
    end
    sb16.push_back({32'd0, 16'd1, 2'b00});
    sb3.push_back({32'd0, 16'd1, 2'b00});
    exp_pkt++;
    bus.m_ready = 1'b1;
    send_beat(32'd0, 1'b1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    drain();
  endtask

  task automatic test_saturate;
    bus.m_ready = 1'b1;
    send_ramp(9);
    drain();
  endtask

  task automatic test_reset_mid;
    bus.m_ready = 1'b1;
    send_beat(32'd0, 1'b0);
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    bus.s_valid = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge counter_clk);
    #1;
    check_reset_state("reset_mid");
    exp_pkt = 0;
    reset = 1'b0;
    @(posedge counter_clk);
    #1;
    send_ramp(2);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_seq_error();
    test_hold();
    test_saturate();
    test_reset_mid();
    repeat (3) @(posedge counter_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
